add_share_arbiter: RTL and testbench

Time-shares one 32-bit adder datapath (register add, add-immediate, load/store address generation) among up to four requesters in the MIPS core. Each requester presents operands and an opcode through a valid/ready handshake. The arbiter grants one request per cycle and computes the sum into a registered response stage. It holds the result until the consumer accepts it. It sits between the decode/issue stage and the adder consumers: writeback, the load unit and the store unit.

---
 rtl/add_share_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_add_share_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_arbiter.sv
// -----------------------------------------------------------------------------
// add_share_arbiter
//
// Shares one W-bit adder (add, addi, lw/sw address generation) among NREQ
// requesters. One request is granted per cycle; its sum is captured in a
// registered response stage, which holds until the consumer accepts it.
// A new request can be accepted in the same cycle the old response drains.
//
// Configuration macro:
//   ADD_SHARE_ARB_RR_EN  defined   -> round-robin grant, pointer resets to 0
//                        undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]    per-requester request valid
//   req_ready  [NREQ]    per-requester accept (combinational, one-hot or zero)
//   req_op     [2*NREQ]  per-requester opcode: 00 add, 01 addi, 10 lw, 11 sw
//   req_a      [W*NREQ]  per-requester operand A
//   req_b      [W*NREQ]  per-requester operand B (op 00 only)
//   req_imm    [16*NREQ] per-requester immediate (op != 00)
//   rsp_valid  response valid
//   rsp_ready  consumer accepts response
//   rsp_id     [2]  owning requester index
//   rsp_op     [2]  opcode of the response
//   rsp_data   [W]  sum modulo 2^W
//   rsp_ovf    signed overflow for add/addi, 0 for lw/sw
// -----------------------------------------------------------------------------
module add_share_arbiter #(
  parameter int NREQ = 3,
  parameter int W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [W*NREQ-1:0]    req_a,
  input  logic [W*NREQ-1:0]    req_b,
  input  logic [16*NREQ-1:0]   req_imm,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [1:0]           rsp_op,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_ovf
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_next_state;

  logic           w_accept;
  logic           w_grant_vld;
  logic [1:0]     w_grant_idx;
  logic           w_load;

  logic [1:0]     w_op;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_rb;
  logic [15:0]    w_imm;
  logic [W-1:0]   w_b;
  logic [W-1:0]   w_sum;
  logic           w_ovf;

  logic [1:0]     r_id;
  logic [1:0]     r_op;
  logic [W-1:0]   r_data;
  logic           r_ovf;

`ifdef ADD_SHARE_ARB_RR_EN
  logic [1:0]     r_ptr;
`endif

  // The response slot can take a new result if it is empty or draining now.
  assign w_accept = (r_state == ST_IDLE) || rsp_ready;

  // NOTE: every signal driven here gets a default first so no latch is inferred
  // on paths where no requester matches.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
`ifdef ADD_SHARE_ARB_RR_EN
    // First pass: indices at or above the pointer. The second pass below then
    // only ever picks an index under the pointer, which gives the wrap-around.
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant_vld && req_valid[i] && (2'(i) >= r_ptr)) begin
        w_grant_vld = 1'b1;
        w_grant_idx = 2'(i);
      end
    end
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant_vld && req_valid[i]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = 2'(i);
      end
    end
  end

  assign w_load = w_accept && w_grant_vld;

  // Gated by rst_n so no requester sees a handshake while reset is held.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n && w_load && (w_grant_idx == 2'(i));
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_op  = '0;
    w_a   = '0;
    w_rb  = '0;
    w_imm = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == 2'(i)) begin
        w_op  = req_op[2*i +: 2];
        w_a   = req_a[W*i +: W];
        w_rb  = req_b[W*i +: W];
        w_imm = req_imm[16*i +: 16];
      end
    end
  end

  assign w_b   = (w_op == 2'b00) ? w_rb : {{(W-16){w_imm[15]}}, w_imm};
  assign w_sum = w_a + w_b;
  // Same-sign operands producing an opposite-sign sum; meaningless for lw/sw.
  assign w_ovf = !w_op[1] && (w_a[W-1] == w_b[W-1]) && (w_sum[W-1] != w_a[W-1]);

  always_comb begin
    w_next_state = r_state;
    if (w_load) begin
      w_next_state = ST_FULL;
    end else if ((r_state == ST_FULL) && rsp_ready) begin
      w_next_state = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the response payload is reset too, since rsp_data is observable
  // and must read zero after reset even though rsp_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id   <= '0;
      r_op   <= '0;
      r_data <= '0;
      r_ovf  <= 1'b0;
    end else if (w_load) begin
      r_id   <= w_grant_idx;
      r_op   <= w_op;
      r_data <= w_sum;
      r_ovf  <= w_ovf;
    end
  end

`ifdef ADD_SHARE_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_load) begin
      r_ptr <= (w_grant_idx == 2'(NREQ-1)) ? 2'd0 : w_grant_idx + 2'd1;
    end
  end
`endif

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_id    = r_id;
  assign rsp_op    = r_op;
  assign rsp_data  = r_data;
  assign rsp_ovf   = r_ovf;

endmodule

// File: tb/tb_add_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add_share_arbiter
//
// Self-checking bench for add_share_arbiter (NREQ=3, W=32). A behavioural
// model tracks pending requests, the response slot and the grant pointer and
// computes sums with 64-bit signed arithmetic. Directed scenarios also check
// fixed expected constants. Honours ADD_SHARE_ARB_RR_EN like the design.
// -----------------------------------------------------------------------------
module tb_add_share_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 32;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [W*NREQ-1:0]   req_a;
  logic [W*NREQ-1:0]   req_b;
  logic [16*NREQ-1:0]  req_imm;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic [1:0]          rsp_op;
  logic [W-1:0]        rsp_data;
  logic                rsp_ovf;

  add_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_imm   (req_imm),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_op    (rsp_op),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Requester side: pending flag and held fields.
  bit          pend  [NREQ];
  logic [1:0]  t_op  [NREQ];
  logic [31:0] t_a   [NREQ];
  logic [31:0] t_b   [NREQ];
  logic [15:0] t_imm [NREQ];

  // Model of the response slot and grant pointer.
  bit          m_valid;
  logic [1:0]  m_id;
  logic [1:0]  m_op;
  logic [31:0] m_data;
  bit          m_ovf;
  int          m_ptr;

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
`ifdef ADD_SHARE_ARB_RR_EN
      int c = (m_ptr + k) % NREQ;
`else
      int c = k;
`endif
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  // Sum as a mathematical integer; overflow means it does not fit in 32 signed.
  function automatic void model_result(input int g, output logic [31:0] d, output bit o);
    longint sa = longint'($signed(t_a[g]));
    longint sb = (t_op[g] == 2'b00) ? longint'($signed(t_b[g])) : longint'($signed(t_imm[g]));
    longint s  = sa + sb;
    d = s[31:0];
    o = (t_op[g][1] == 1'b0) && (s != longint'($signed(s[31:0])));
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_id    = '0;
    m_op    = '0;
    m_data  = '0;
    m_ovf   = 0;
    m_ptr   = 0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend[i];
      req_op[2*i +: 2]      = t_op[i];
      req_a[W*i +: W]       = t_a[i];
      req_b[W*i +: W]       = t_b[i];
      req_imm[16*i +: 16]   = t_imm[i];
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm);
    pend[i]  = 1;
    t_op[i]  = op;
    t_a[i]   = a;
    t_b[i]   = b;
    t_imm[i] = imm;
  endtask

  // One clock: check combinational req_ready, clock, update model, check rsp_*.
  // Returns the granted index (-1 if none).
  task automatic cycle(input string tag, output int granted);
    int               g;
    bit               acc;
    logic [NREQ-1:0]  exp_ready;
    logic [31:0]      d;
    bit               o;
    apply_inputs();
    #1;
    g         = model_grant();
    acc       = !m_valid || rsp_ready;
    exp_ready = '0;
    if (acc && g >= 0) exp_ready[g] = 1'b1;
    n_cmp++;
    if (req_ready !== exp_ready) begin
      n_bad++;
      $display("FAIL %s req_ready: got %b expected %b", tag, req_ready, exp_ready);
    end
    @(posedge clk);
    granted = -1;
    if (acc && g >= 0) begin
      model_result(g, d, o);
      m_valid = 1;
      m_id    = 2'(g);
      m_op    = t_op[g];
      m_data  = d;
      m_ovf   = o;
      m_ptr   = (g + 1) % NREQ;
      pend[g] = 0;
      granted = g;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    #1;
    n_cmp++;
    if (rsp_valid !== m_valid) begin
      n_bad++;
      $display("FAIL %s rsp_valid: got %b expected %b", tag, rsp_valid, m_valid);
    end
    if (m_valid) begin
      n_cmp++;
      if (rsp_id !== m_id || rsp_op !== m_op || rsp_data !== m_data || rsp_ovf !== m_ovf) begin
        n_bad++;
        $display("FAIL %s rsp: got id=%0d op=%0d data=%h ovf=%b expected id=%0d op=%0d data=%h ovf=%b",
                 tag, rsp_id, rsp_op, rsp_data, rsp_ovf, m_id, m_op, m_data, m_ovf);
      end
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
  endtask

  task automatic drain();
    int g;
    clear_pend();
    rsp_ready = 1'b1;
    cycle("drain", g);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int g;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 32'(i + 1), 32'h10, 16'h0);
    rsp_ready = 1'b1;
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || req_ready !== '0 ||
        rsp_id !== 2'd0 || rsp_op !== 2'd0 || rsp_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b data=%h ready=%b id=%0d op=%0d ovf=%b expected all zero",
               rsp_valid, rsp_data, req_ready, rsp_id, rsp_op, rsp_ovf);
    end
    rst_n = 1'b1;
    cycle("reset_first", g);
    n_cmp++;
    if (rsp_id !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_first_grant: got id %0d expected 0", rsp_id);
    end
    drain();
    drain();
  endtask

  task automatic test_add();
    int g;
    clear_pend();
    rsp_ready = 1'b1;
    set_req(0, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 16'h1234);
    cycle("add", g);
    n_cmp++;
    if (rsp_data !== 32'h8000_0000 || rsp_ovf !== 1'b1 || rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL add_const: got data=%h ovf=%b id=%0d valid=%b expected 80000000 1 0 1",
               rsp_data, rsp_ovf, rsp_id, rsp_valid);
    end
    drain();
  endtask

  task automatic test_lw();
    int g;
    clear_pend();
    rsp_ready = 1'b1;
    set_req(1, 2'b10, 32'h0000_1000, 32'hDEAD_BEEF, 16'hFFFC);
    cycle("lw", g);
    n_cmp++;
    if (rsp_data !== 32'h0000_0FFC || rsp_ovf !== 1'b0 || rsp_id !== 2'd1 || rsp_op !== 2'b10) begin
      n_bad++;
      $display("FAIL lw_const: got data=%h ovf=%b id=%0d op=%0d expected 00000ffc 0 1 2",
               rsp_data, rsp_ovf, rsp_id, rsp_op);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int g;
    int exp_id;
    do_reset();
    clear_pend();
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) set_req(i, 2'(($urandom_range(0, 3))), $urandom, $urandom, 16'($urandom));
      cycle("rr", g);
`ifdef ADD_SHARE_ARB_RR_EN
      exp_id = c % NREQ;
`else
      exp_id = 0;
`endif
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id)) begin
        n_bad++;
        $display("FAIL rr_seq[%0d]: got valid=%b id=%0d expected valid=1 id=%0d", c, rsp_valid, rsp_id, exp_id);
      end
    end
    drain();
    drain();
    drain();
  endtask

  task automatic test_backpressure();
    int          g;
    logic [1:0]  s_id;
    logic [31:0] s_data;
    clear_pend();
    rsp_ready = 1'b1;
    set_req(0, 2'b01, 32'h0000_0100, 32'h0, 16'h8000);
    cycle("bp_fill", g);
    s_id   = rsp_id;
    s_data = rsp_data;
    set_req(2, 2'b11, 32'h2000_0000, 32'h0, 16'h0010);
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle("bp_stall", g);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== s_id || rsp_data !== s_data || req_ready !== '0) begin
        n_bad++;
        $display("FAIL bp_stable[%0d]: got valid=%b id=%0d data=%h ready=%b expected 1 %0d %h 000",
                 c, rsp_valid, rsp_id, rsp_data, req_ready, s_id, s_data);
      end
    end
    rsp_ready = 1'b1;
    cycle("bp_release", g);
    n_cmp++;
    if (g != 2 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h2000_0010) begin
      n_bad++;
      $display("FAIL bp_release: got valid=%b id=%0d data=%h expected 1 2 20000010",
               rsp_valid, rsp_id, rsp_data);
    end
    drain();
  endtask

  task automatic test_async_reset();
    int g;
    clear_pend();
    rsp_ready = 1'b0;
    set_req(1, 2'b00, 32'h5, 32'h6, 16'h0);
    cycle("ar_fill", g);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset_drop: got valid=%b data=%h expected 0 00000000", rsp_valid, rsp_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_pend();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, 32'(i * 100), 32'h0, 16'(i));
    cycle("ar_first", g);
    n_cmp++;
    if (rsp_id !== 2'd0) begin
      n_bad++;
      $display("FAIL async_reset_first_grant: got id %0d expected 0", rsp_id);
    end
    drain();
    drain();
    drain();
  endtask

  task automatic test_random();
    int g;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 55) begin
          case ($urandom_range(0, 3))
            0: set_req(i, 2'($urandom_range(0, 3)), 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)),
                       32'h0000_0010 + 32'($urandom_range(0, 31)), 16'($urandom));
            1: set_req(i, 2'($urandom_range(0, 3)), 32'h8000_0000 + 32'($urandom_range(0, 31)),
                       32'hFFFF_FFF0 - 32'($urandom_range(0, 31)), 16'h8000 | 16'($urandom));
            default: set_req(i, 2'($urandom_range(0, 3)), $urandom, $urandom, 16'($urandom));
          endcase
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      cycle("random", g);
    end
    drain();
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_imm   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; t_op[i] = '0; t_a[i] = '0; t_b[i] = '0; t_imm[i] = '0;
    end
    model_reset();
    #1;
    test_reset();
    test_add();
    test_lw();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
